// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/single-step/halt control for a divided CPU clock
// Button debouncing is enabled by defining CPU_RUN_CTRL_DEBOUNCE_EN.
module cpu_run_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 32
) (
   input  logic             clk_board,
   input  logic             rst_n,
   input  logic             btn_run,
   input  logic             btn_step,
   input  logic             btn_halt,
   input  logic             clk_cpu,
   output logic             stop,
   output logic             running,
   output logic             step_busy,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;

   localparam int RUN_B  = 0;
   localparam int STEP_B = 1;
   localparam int HALT_B = 2;

   state_t     state;
   logic [2:0] btn_raw;
   logic [2:0] sync_a;
   logic [2:0] sync_b;
   logic [2:0] deb;
   logic [2:0] deb_q;
   logic [2:0] press;
   logic       cpu_q;
   logic       cpu_qq;
   logic       rise;

   assign btn_raw = {btn_halt, btn_step, btn_run};

   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
         cpu_q  <= 1'b0;
         cpu_qq <= 1'b0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         cpu_q  <= clk_cpu;
         cpu_qq <= cpu_q;
      end
   end

`ifdef CPU_RUN_CTRL_DEBOUNCE_EN
   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_W-1:0] db_cnt [3];

   // A level is accepted only after differing from the current one for
   // DEBOUNCE_CYCLES consecutive cycles; any return restarts the count.
   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         deb <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync_b[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   logic unused_debounce;
   assign unused_debounce = (DEBOUNCE_CYCLES > 0);
   assign deb = sync_b;
`endif

   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) deb_q <= '0;
      else        deb_q <= deb;
   end

   assign press = deb & ~deb_q;
   assign rise  = cpu_q & ~cpu_qq;

   // Edges seen while frozen are divider latency, not executed CPU cycles.
   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HALT;
         stop      <= 1'b1;
         running   <= 1'b0;
         step_busy <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         if (rise && !stop) cycle_cnt <= cycle_cnt + 1'b1;
         case (state)
            HALT: begin
               if (!press[HALT_B] && press[STEP_B]) begin
                  state     <= STEP;
                  stop      <= 1'b0;
                  step_busy <= 1'b1;
               end else if (!press[HALT_B] && press[RUN_B]) begin
                  state     <= RUN;
                  stop      <= 1'b0;
                  running   <= 1'b1;
               end
            end
            RUN: begin
               if (press[HALT_B]) begin
                  state     <= STEP;
                  running   <= 1'b0;
                  step_busy <= 1'b1;
               end
            end
            STEP: begin
               if (rise) begin
                  state     <= HALT;
                  stop      <= 1'b1;
                  step_busy <= 1'b0;
               end
            end
            default: begin
               state     <= HALT;
               stop      <= 1'b1;
               running   <= 1'b0;
               step_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

   localparam int DB = 4;

   typedef struct packed {
      logic        stop;
      logic        run;
      logic        busy;
      logic [31:0] cnt;
   } ev_t;

   logic        clk_board = 1'b0;
   logic        rst_n     = 1'b0;
   logic        btn_run   = 1'b0;
   logic        btn_step  = 1'b0;
   logic        btn_halt  = 1'b0;
   logic        clk_cpu   = 1'b0;
   logic        stop, running, step_busy;
   logic [31:0] cycle_cnt;
   logic        stop_w, running_w, busy_w;
   logic [2:0]  cnt_w;

   int          checks = 0;
   int          errors = 0;
   ev_t         exp_q[$];
   logic        mon_en = 1'b0;
   logic [40:0] cur, prev, want;
   ev_t         e;
   logic [31:0] m_cnt = 32'd0;
   int          k;

   always #5 clk_board = ~clk_board;

   cpu_run_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(32)) dut (
      .clk_board(clk_board), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
      .btn_halt(btn_halt), .clk_cpu(clk_cpu), .stop(stop), .running(running),
      .step_busy(step_busy), .cycle_cnt(cycle_cnt)
   );

   // Narrow counter twin driven identically, so the wrap is reachable.
   cpu_run_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut_w (
      .clk_board(clk_board), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
      .btn_halt(btn_halt), .clk_cpu(clk_cpu), .stop(stop_w), .running(running_w),
      .step_busy(busy_w), .cycle_cnt(cnt_w)
   );

   always @(negedge clk_board) begin
      cur = {stop, running, step_busy, cycle_cnt, stop_w, running_w, busy_w, cnt_w};
      if (mon_en && cur !== prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got=%h required=none", cur);
         end else begin
            e    = exp_q.pop_front();
            want = {e.stop, e.run, e.busy, e.cnt, e.stop, e.run, e.busy, e.cnt[2:0]};
            if (cur !== want) begin
               errors++;
               $display("FAIL event got=%h required=%h", cur, want);
            end
         end
      end
      prev = cur;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_board);
      #1;
   endtask

   task automatic push(input logic s, input logic r, input logic b, input logic [31:0] c);
      exp_q.push_back({s, r, b, c});
   endtask

   task automatic press(input int which, input int n);
      btn_run  = (which == 0);
      btn_step = (which == 1);
      btn_halt = (which == 2);
      tick(n);
      btn_run  = 1'b0;
      btn_step = 1'b0;
      btn_halt = 1'b0;
   endtask

   task automatic cpu_pulse();
      clk_cpu = 1'b1;
      tick(5);
      clk_cpu = 1'b0;
      tick(5);
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic wait_drain(input string name);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 300) begin
         tick(1);
         i++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      check("reset_state", 64'({stop, running, step_busy, cycle_cnt}), 64'({3'b100, 32'd0}));
      rst_n = 1'b1;
      tick(2);
      mon_en = 1'b1;

      // idle in HALT with the CPU clock toggling: no event may appear
      for (int i = 0; i < 20; i++) begin
         clk_cpu = ~clk_cpu;
         tick(10);
      end
      check("idle_halt", 64'({stop, running, step_busy, cycle_cnt}), 64'({3'b100, 32'd0}));

      // single step
      push(1'b0, 1'b0, 1'b1, m_cnt);
      press(1, 10);
      wait_drain("step_enter");
      m_cnt++;
      push(1'b1, 1'b0, 1'b0, m_cnt);
      cpu_pulse();
      wait_drain("step_done");
      check("step_cnt", 64'(cycle_cnt), 64'(32'd1));
      tick(10);

      // 3-cycle glitch on btn_step
`ifndef CPU_RUN_CTRL_DEBOUNCE_EN
      push(1'b0, 1'b0, 1'b1, m_cnt);
`endif
      press(1, 3);
      tick(20);
`ifndef CPU_RUN_CTRL_DEBOUNCE_EN
      m_cnt++;
      push(1'b1, 1'b0, 1'b0, m_cnt);
      cpu_pulse();
`endif
      wait_drain("glitch");
      check("glitch_stop", 64'(stop), 64'(1'b1));
      tick(10);

      // run, ignored presses, five cycles, halt drains one more
      push(1'b0, 1'b1, 1'b0, m_cnt);
      press(0, 8);
      wait_drain("run_enter");
      tick(10);
      press(1, 8);
      tick(10);
      press(0, 8);
      tick(10);
      check("run_ignores_presses", 64'({stop, running, step_busy}), 64'(3'b010));
      for (int i = 0; i < 5; i++) begin
         m_cnt++;
         push(1'b0, 1'b1, 1'b0, m_cnt);
         cpu_pulse();
      end
      wait_drain("run_cycles");
      push(1'b0, 1'b0, 1'b1, m_cnt);
      press(2, 8);
      wait_drain("halt_to_step");
      m_cnt++;
      push(1'b1, 1'b0, 1'b0, m_cnt);
      cpu_pulse();
      wait_drain("drain_done");
      check("run_total", 64'(cycle_cnt), 64'(m_cnt));
      tick(10);

      // halt+step together in RUN; drain edge wraps the narrow counter
      push(1'b0, 1'b1, 1'b0, m_cnt);
      press(0, 8);
      wait_drain("run_enter2");
      k = int'((m_cnt + 32'd1) & 32'd7);
      k = (8 - k) % 8;
      for (int i = 0; i < k; i++) begin
         m_cnt++;
         push(1'b0, 1'b1, 1'b0, m_cnt);
         cpu_pulse();
      end
      wait_drain("pre_wrap");
      push(1'b0, 1'b0, 1'b1, m_cnt);
      btn_halt = 1'b1;
      btn_step = 1'b1;
      tick(8);
      btn_halt = 1'b0;
      btn_step = 1'b0;
      wait_drain("halt_step_same");
      m_cnt++;
      push(1'b1, 1'b0, 1'b0, m_cnt);
      cpu_pulse();
      wait_drain("wrap_drain");
      check("narrow_wrapped", 64'(cnt_w), 64'(3'd0));
      check("wide_cnt", 64'(cycle_cnt), 64'(m_cnt));
      tick(10);

      // held run button, one-cycle reset mid-RUN, held button presses once more
      push(1'b0, 1'b1, 1'b0, m_cnt);
      btn_run = 1'b1;
      tick(10);
      wait_drain("run_held");
      m_cnt++;
      push(1'b0, 1'b1, 1'b0, m_cnt);
      cpu_pulse();
      wait_drain("run_held_cycle");
      m_cnt = 32'd0;
      push(1'b1, 1'b0, 1'b0, 32'd0);
      push(1'b0, 1'b1, 1'b0, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 64'({stop, running, step_busy, cycle_cnt}), 64'({3'b100, 32'd0}));
      @(posedge clk_board);
      #1;
      rst_n = 1'b1;
      tick(40);
      wait_drain("held_after_reset");
      btn_run = 1'b0;
      tick(10);
      push(1'b0, 1'b0, 1'b1, m_cnt);
      press(2, 8);
      wait_drain("final_halt");
      m_cnt++;
      push(1'b1, 1'b0, 1'b0, m_cnt);
      cpu_pulse();
      wait_drain("final_drain");
      check("final_state", 64'({stop, running, step_busy, cycle_cnt}), 64'({3'b100, 32'd1}));
      tick(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, board-clock cycles a synchronized button level must stay stable before being accepted.
REQ-002 Parameter CNT_W, default 32, width of cycle_cnt.
REQ-003 clk_board  input  1  board clock; the only clock of the block; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_run  input  1  raw run push-button, active-high, asynchronous to clk_board.
REQ-006 btn_step  input  1  raw single-step push-button, active-high, asynchronous.
REQ-007 btn_halt  input  1  raw halt push-button, active-high, asynchronous.
REQ-008 clk_cpu  input  1  divided CPU clock, sampled as data (never used as a clock).
REQ-009 stop  output  1  freeze request to the clock divider; 1 holds clk_cpu at its current level.
REQ-010 running  output  1  1 while in state RUN.
REQ-011 step_busy  output  1  1 while in state STEP.
REQ-012 cycle_cnt  output  CNT_W  number of CPU rising edges completed while stop=0.

Function
REQ-013 Each button passes through a 2-flop synchronizer, then the debouncer (REQ-027), giving a debounced level; a press is a 1-cycle pulse on its 0->1 transition.
REQ-014 clk_cpu is registered once (cpu_q) and again (cpu_qq); rise = cpu_q & ~cpu_qq.
REQ-015 States: HALT, RUN, STEP; stop, running, step_busy are registered decodes of the state (stop=1 only in HALT).
REQ-016 HALT: step press -> STEP; run press -> RUN; otherwise stay.
REQ-017 RUN: halt press -> STEP (drain current CPU cycle); run and step presses ignored.
REQ-018 STEP: on rise -> HALT; button presses ignored while in STEP.
REQ-019 Simultaneous presses in the same cycle: halt > step > run.
REQ-020 stop rises in the clk_board cycle after the cycle in which rise is detected in STEP; stop falls in the cycle after the press pulse in HALT.
REQ-021 cycle_cnt increments by 1 on every cycle with rise=1 and registered stop=0; wraps 2^CNT_W-1 -> 0 without flag.
REQ-022 rise while stop=1 (divider freeze latency) does not increment cycle_cnt and does not change state.
REQ-023 Debouncer counter restarts on any change of the synchronized level before DEBOUNCE_CYCLES is reached; glitches shorter than DEBOUNCE_CYCLES produce no press.
REQ-024 A button held continuously produces exactly one press.

Reset
REQ-025 While rst_n=0: state HALT, stop=1, running=0, step_busy=0, cycle_cnt=0, synchronizers, cpu_q, cpu_qq, debounced levels and debounce counters all 0.
REQ-026 Reset asserted mid-STEP or mid-RUN forces HALT immediately (asynchronously); after release no press is generated for a button already held until it is released and pressed again? No -- a held button produces one press once its debounced level reaches 1 after release.

Configuration
REQ-027 Macro CPU_RUN_CTRL_DEBOUNCE_EN: defined -> debouncer per REQ-023 with DEBOUNCE_CYCLES; undefined -> debounced level equals synchronizer output, no counters, DEBOUNCE_CYCLES ignored.

Verification (DEBOUNCE_CYCLES=4, macro defined unless noted)
REQ-028 Reset release, no buttons, clk_cpu toggling every 10 cycles -> stop=1, state HALT, cycle_cnt=0 for 200 cycles.
REQ-029 btn_step high 10 cycles in HALT -> stop=0, step_busy=1; first rise -> stop=1 next cycle, cycle_cnt=1, state HALT.
REQ-030 btn_run pulse, then 5 clk_cpu rises, then btn_halt -> cycle_cnt=6 after drain rise, stop=1, running=0.
REQ-031 btn_step glitch high 3 cycles -> no press, stop stays 1; macro undefined, same glitch -> STEP entered.
REQ-032 btn_halt and btn_step asserted same cycle in RUN -> STEP (drain), then HALT; cycle_cnt preloaded 0xFFFFFFFF wraps to 0 on the drain rise.
REQ-033 rst_n low for 1 cycle mid-RUN -> stop=1 asynchronously, cycle_cnt=0, state HALT.
